// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if: plaintext-in / ciphertext-out valid/ready bundle.
// master drives in_valid, plaintext, keyschedule, out_ready; slave (core) drives the rest.
interface aes_cipher_iter_if #(
  parameter int nr = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic [0:127]             plaintext;
  logic [0:128*(nr+1)-1]    keyschedule;
  logic                     out_valid;
  logic                     out_ready;
  logic [0:127]             ciphertext;
  logic                     busy;

  modport master (
    output in_valid,
    output plaintext,
    output keyschedule,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  keyschedule,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext,
    output busy
  );
endinterface

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encrypt, one round per clock, nk/nr selects 128/192/256.
// Ports: clk, rst (async high), io (slave: in_valid/in_ready/plaintext/keyschedule,
// out_valid/out_ready/ciphertext, busy). Optional: AES_CIPHER_KEY_LATCH_EN latches keys.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = tbl[{a, 3'b000} +: 8];
endmodule

module aes_cipher_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input logic clk,
  input logic rst,
  aes_cipher_iter_if.slave io
);
  if ((nr != nk + 6) || (nr < 10) || (nr > 14)) begin : g_bad_cfg
    $error("aes_cipher_iter: nk/nr pair is not an AES variant");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [3:0]   round;
  logic [0:127] st;
  logic [0:127] sb;
  logic [0:127] sr;
  logic [0:127] mc;
  logic [0:127] rk_cur;
  logic [0:127] rk [1:nr];
  logic         last;

  assign last = (round == 4'(nr));

`ifdef AES_CIPHER_KEY_LATCH_EN
  // Round key 0 is consumed on the accept edge itself,
  // so only rounds 1..nr need to be held.
  logic [0:128*nr-1] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
    end else if (state == IDLE && io.in_valid) begin
      key_q <= io.keyschedule[128 +: 128*nr];
    end
  end
`endif

  for (genvar i = 1; i <= nr; i++) begin : g_rk
`ifdef AES_CIPHER_KEY_LATCH_EN
    assign rk[i] = key_q[128*(i-1) +: 128];
`else
    assign rk[i] = io.keyschedule[128*i +: 128];
`endif
  end

  always_comb begin
    rk_cur = '0;
    for (int i = 1; i <= nr; i++) begin
      if (round == 4'(i)) rk_cur = rk[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (
      .a(st[8*i +: 8]),
      .y(sb[8*i +: 8])
    );
  end

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
      end
    end
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[32*c +: 8];
      a1 = sr[32*c+8 +: 8];
      a2 = sr[32*c+16 +: 8];
      a3 = sr[32*c+24 +: 8];
      mc[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (io.in_valid)  state_nx = RUN;
      (state == RUN):  if (last)         state_nx = DONE;
      (state == DONE): if (io.out_ready) state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready   = 1'b0;
    io.out_valid  = 1'b0;
    io.busy       = 1'b0;
    io.ciphertext = '0;
    unique case (1'b1)
      (state == IDLE): io.in_ready = 1'b1;
      (state == RUN):  io.busy = 1'b1;
      (state == DONE): begin
        io.busy       = 1'b1;
        io.out_valid  = 1'b1;
        io.ciphertext = st;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= '0;
      round <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            st    <= io.plaintext ^ io.keyschedule[0:127];
            round <= 4'd1;
          end
        end
        RUN: begin
          st    <= last ? (sr ^ rk_cur) : (mc ^ rk_cur);
          round <= last ? 4'd0 : round + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
